// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (adds the HALT state).
package fetch_pkg;

    localparam int          INSTR_BYTES          = 4;
    localparam int          OPCODE_W             = 7;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_WAIT,
        ST_DRAIN
`ifdef FETCH_MISALIGN_CHECK_EN
        , ST_HALT
`endif
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/grant/response bus.
// Signal suffixes are relative to the fetch unit (master side).
interface instr_fetch_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req_o;
    logic [ADDR_WIDTH-1:0] imem_addr_o;
    logic                  imem_gnt_i;
    logic                  imem_rvalid_i;
    logic [DATA_WIDTH-1:0] imem_rdata_i;

    // Fetch unit side
    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    // Memory side
    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/fetch_out_buf.sv
// One-entry valid/ready output buffer holding {instr, pc}.
// Clear has priority over load; data is held after a transfer so the
// outputs only change on a load or reset.
module fetch_out_buf #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_clear,
    input  logic                  i_ready,
    input  logic [DATA_WIDTH-1:0] i_instr,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0] o_pc
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_instr;
    logic [ADDR_WIDTH-1:0] r_pc;

    // Buffer occupancy and payload update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one outstanding word read at
// a time and hands fetched instructions to decode through fetch_out_buf.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned redirect halts).
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEFAULT_RESET_VECTOR)
)(
    input  logic                    clk,
    input  logic                    rst,
    instr_fetch_unit_if.master      imem,
    input  logic                    redirect_i,
    input  logic [ADDR_WIDTH-1:0]   redirect_pc_i,
    input  logic                    instr_ready_i,
    output logic                    instr_valid_o,
    output logic [DATA_WIDTH-1:0]   instr_o,
    output logic [OPCODE_W-1:0]     opcode_o,
    output logic [ADDR_WIDTH-1:0]   pc_o,
    output logic                    misalign_o
);

    fetch_state_t          r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_req_pc;

    logic                  w_req;
    logic                  w_fire;
    logic                  w_load;
    logic                  w_clear;
    logic                  w_valid;
    logic [ADDR_WIDTH-1:0] w_redirect_pc;
    logic                  w_misalign_redir;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_misalign;
    assign w_misalign_redir = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    assign w_redirect_pc    = redirect_pc_i;
    assign misalign_o       = r_misalign;
    // Halted: keep the buffer empty so nothing reaches decode
    assign w_clear          = redirect_i || (r_state == ST_HALT);
`else
    logic w_unused_lsbs;
    assign w_unused_lsbs    = ^redirect_pc_i[1:0];
    assign w_misalign_redir = 1'b0;
    assign w_redirect_pc    = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
    assign misalign_o       = 1'b0;
    assign w_clear          = redirect_i;
`endif

    // Request only when the buffer will be free by the time data returns
    always_comb begin
        w_req = 1'b0;
        if (!rst && r_state == ST_FETCH)
            w_req = !w_valid || instr_ready_i;
    end

    assign w_fire           = w_req && imem.imem_gnt_i;
    assign w_load           = (r_state == ST_WAIT) && imem.imem_rvalid_i;
    assign imem.imem_req_o  = w_req;
    assign imem.imem_addr_o = r_pc;

    // Fetch FSM and PC; a redirect overrides the normal transition
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_FETCH;
            r_pc     <= RESET_VECTOR;
            r_req_pc <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            r_misalign <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (w_fire) begin
                        r_req_pc <= r_pc;
                        r_pc     <= r_pc + ADDR_WIDTH'(INSTR_BYTES);
                        r_state  <= ST_WAIT;
                    end
                end
                ST_WAIT:  if (imem.imem_rvalid_i) r_state <= ST_FETCH;
                ST_DRAIN: if (imem.imem_rvalid_i) r_state <= ST_FETCH;
                default:  r_state <= r_state;
            endcase

            if (redirect_i && w_misalign_redir) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                r_misalign <= 1'b1;
                r_state    <= ST_HALT;
`endif
            end else if (redirect_i) begin
                r_pc <= w_redirect_pc;
                case (r_state)
                    ST_FETCH: r_state <= w_fire ? ST_DRAIN : ST_FETCH;
                    // A response landing with the redirect is the stale one
                    // itself; waiting in DRAIN for another would deadlock.
                    ST_WAIT:  r_state <= imem.imem_rvalid_i ? ST_FETCH : ST_DRAIN;
                    ST_DRAIN: r_state <= imem.imem_rvalid_i ? ST_FETCH : ST_DRAIN;
                    default:  r_state <= r_state;
                endcase
            end
        end
    end

    fetch_out_buf #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_buf (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_clear (w_clear),
        .i_ready (instr_ready_i),
        .i_instr (imem.imem_rdata_i),
        .i_pc    (r_req_pc),
        .o_valid (w_valid),
        .o_instr (instr_o),
        .o_pc    (pc_o)
    );

    assign instr_valid_o = w_valid;
    assign opcode_o      = instr_o[OPCODE_W-1:0];

endmodule
